// File: rtl/fpu_host_ctrl.sv
// Sol-1 bus host controller for the FPU core: byte-wise operand staging, command issue,
// done/ack handshake and result readback. Define FPU_HOST_TIMEOUT_EN to add a watchdog.
module fpu_host_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        cs,
    input  logic        rd,
    input  logic        wr,
    input  logic [3:0]  addr,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        irq,
    output logic        fpu_start,
    output logic [3:0]  fpu_operation,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    input  logic [31:0] fpu_result,
    input  logic        fpu_done,
    output logic        fpu_ack
);

    typedef enum logic [1:0] {StIdle, StStart, StWait, StAck} state_e;

    state_e      state_q, state_d;
    logic [31:0] a_stage_q, a_stage_d;
    logic [31:0] b_stage_q, b_stage_d;
    logic [31:0] fpu_a_q, fpu_a_d;
    logic [31:0] fpu_b_q, fpu_b_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] result_q, result_d;
    logic        irq_en_q, irq_en_d;
    logic        done_q, done_d;
    logic        err_op_q, err_op_d;
    logic        err_ovr_q, err_ovr_d;

    logic wr_en, cmd_wr, stat_rd, is_idle, op_valid;
    logic cmd_accept, cmd_bad, cmd_ovr;
    logic done_set, capture, busy;
    logic tmo_hit, err_tmo;
    logic [7:0] status;

    assign wr_en      = cs & wr;
    assign cmd_wr     = wr_en & (addr == 4'hC);
    assign stat_rd    = cs & rd & (addr == 4'hC);
    assign is_idle    = (state_q == StIdle);
    assign op_valid   = (data_in[3:0] <= 4'hA);
    assign cmd_accept = cmd_wr & is_idle & op_valid;
    assign cmd_bad    = cmd_wr & is_idle & ~op_valid;
    assign cmd_ovr    = cmd_wr & ~is_idle;
    // A watchdog expiry pre-empts both the capture and the done handshake.
    assign capture    = (state_q == StWait) & fpu_done & ~tmo_hit;
    assign done_set   = (state_q == StAck) & ~fpu_done & ~tmo_hit;

`ifdef FPU_HOST_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            err_tmo_q, err_tmo_d;
    logic            tmo_run;

    assign tmo_run = (state_q == StWait) | (state_q == StAck);
    assign tmo_hit = tmo_run & (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
    assign err_tmo = err_tmo_q;

    always_comb begin
        tmo_cnt_d = '0;
        if (tmo_run) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
        err_tmo_d = err_tmo_q;
        if (stat_rd) begin
            err_tmo_d = 1'b0;
        end
        if (tmo_hit) begin
            err_tmo_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            tmo_cnt_q <= '0;
            err_tmo_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_tmo_q <= err_tmo_d;
        end
    end
`else
    logic unused_tmo_param;

    assign tmo_hit          = 1'b0;
    assign err_tmo          = 1'b0;
    assign unused_tmo_param = |TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (cmd_accept) state_d = StStart;
            StStart: state_d = StWait;
            StWait: begin
                if (tmo_hit) begin
                    state_d = StIdle;
                end else if (fpu_done) begin
                    state_d = StAck;
                end
            end
            StAck:   if (tmo_hit || !fpu_done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        fpu_start = (state_q == StStart);
        fpu_ack   = (state_q == StAck);
        busy      = (state_q != StIdle);
    end

    always_comb begin
        a_stage_d = a_stage_q;
        b_stage_d = b_stage_q;
        if (wr_en && addr[3:2] == 2'b00) begin
            a_stage_d[{addr[1:0], 3'b000} +: 8] = data_in;
        end
        if (wr_en && addr[3:2] == 2'b01) begin
            b_stage_d[{addr[1:0], 3'b000} +: 8] = data_in;
        end

        fpu_a_d  = fpu_a_q;
        fpu_b_d  = fpu_b_q;
        op_d     = op_q;
        irq_en_d = irq_en_q;
        if (cmd_accept) begin
            fpu_a_d = a_stage_q;
            fpu_b_d = b_stage_q;
            op_d    = data_in[3:0];
        end
        if (cmd_accept || cmd_bad) begin
            irq_en_d = data_in[7];
        end

        result_d = capture ? fpu_result : result_q;

        // Status-read clear first, so a same-cycle set event wins.
        done_d    = done_q;
        err_op_d  = err_op_q;
        err_ovr_d = err_ovr_q;
        if (stat_rd) begin
            done_d    = 1'b0;
            err_op_d  = 1'b0;
            err_ovr_d = 1'b0;
        end
        if (cmd_accept) done_d = 1'b0;
        if (done_set)   done_d = 1'b1;
        if (cmd_bad)    err_op_d = 1'b1;
        if (cmd_ovr)    err_ovr_d = 1'b1;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            a_stage_q <= '0;
            b_stage_q <= '0;
            fpu_a_q   <= '0;
            fpu_b_q   <= '0;
            op_q      <= '0;
            result_q  <= '0;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            err_op_q  <= 1'b0;
            err_ovr_q <= 1'b0;
        end else begin
            a_stage_q <= a_stage_d;
            b_stage_q <= b_stage_d;
            fpu_a_q   <= fpu_a_d;
            fpu_b_q   <= fpu_b_d;
            op_q      <= op_d;
            result_q  <= result_d;
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
            err_op_q  <= err_op_d;
            err_ovr_q <= err_ovr_d;
        end
    end

    assign status = {irq_en_q, 2'b00, err_tmo, err_ovr_q, err_op_q, done_q, busy};

    always_comb begin
        data_out = 8'h00;
        case (addr[3:2])
            2'b00:   data_out = a_stage_q[{addr[1:0], 3'b000} +: 8];
            2'b01:   data_out = b_stage_q[{addr[1:0], 3'b000} +: 8];
            2'b10:   data_out = result_q[{addr[1:0], 3'b000} +: 8];
            default: if (addr[1:0] == 2'b00) data_out = status;
        endcase
    end

    assign irq           = done_q & irq_en_q;
    assign fpu_operation = op_q;
    assign fpu_a         = fpu_a_q;
    assign fpu_b         = fpu_b_q;

endmodule

// File: doc/fpu_host_ctrl.md
Name: fpu_host_ctrl

Overview:
- CPU-side initiator for the FPU core; the FPU core is the responder.
- Presents 8-bit register access to the Sol-1 bus.
- Assembles 32-bit operands byte-wise, issues an operation, and completes the FPU's done/ack handshake.
- Holds the result for byte-wise readback, with status flags and an optional interrupt.

Parameters:
- TIMEOUT_CYCLES, 4096: watchdog limit in clocks. Used only with FPU_HOST_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- arst  in  1  asynchronous reset, active-high
- cs  in  1  chip select
- rd  in  1  read strobe, one cycle, qualified by cs
- wr  in  1  write strobe, one cycle, qualified by cs
- addr  in  4  register address
- data_in  in  8  CPU write data
- data_out  out  8  CPU read data, combinational from addr
- irq  out  1  interrupt = done_flag & irq_en
- fpu_start  out  1  one-cycle start pulse to FPU
- fpu_operation  out  4  op code, encoding: add=0, sub=1, mul=2, square=3, div=4, sqrt=5, sin=6, cos=7, tan=8, ln=9, exp=A
- fpu_a  out  32  latched operand A
- fpu_b  out  32  latched operand B
- fpu_result  in  32  FPU result, valid while fpu_done=1
- fpu_done  in  1  FPU result valid; held until ack is seen
- fpu_ack  out  1  acknowledge to FPU

Behaviour:
- Reset state (arst high, any time, including mid-operation):
  - FSM returns to idle; all registers cleared.
  - data_out=0, irq=0, fpu_start=0, fpu_ack=0, fpu_operation=0, fpu_a=0, fpu_b=0.
- Address map:
  - 0x0-0x3: A bytes, LSB first, R/W.
  - 0x4-0x7: B bytes, LSB first, R/W.
  - 0x8-0xB: result bytes, LSB first, read-only; writes ignored.
  - 0xC write = command: bits[3:0] op, bit7 irq_en.
  - 0xC read = status: b0 busy, b1 done, b2 err_op, b3 err_ovr, b4 err_tmo, b7 irq_en, others 0.
  - 0xD-0xF: read 0x00, writes ignored.
- Operand staging: A/B staging registers are writable at any time, including while busy. The in-flight op is unaffected because fpu_a/fpu_b are latched copies.
- Command accept (wr & cs & addr=0xC, state idle, op<=0xA):
  - Latch fpu_operation, fpu_a, fpu_b and irq_en.
  - Clear done_flag.
  - Go to start_st.
- Invalid command (op 0xB-0xF while idle): not issued; set err_op; irq_en still updated; stay idle.
- Command while busy: ignored entirely (irq_en unchanged); set err_ovr.
- FSM states:
  - idle_st: busy=0.
  - start_st: fpu_start=1 for exactly one cycle, then wait_st.
  - wait_st: when fpu_done is sampled 1, capture fpu_result into the result register and go to ack_st.
  - ack_st: fpu_ack=1 until fpu_done is sampled 0; then set done_flag and go to idle_st.
- busy = (state != idle_st).
- Latency: command write at edge N → fpu_start high during cycle N+1 → wait_st from N+2. done_flag rises one edge after fpu_done drops.
- Status read (rd & cs & addr=0xC):
  - data_out shows the pre-clear value.
  - done_flag, err_op, err_ovr and err_tmo clear at that edge.
  - If a set event for the same flag occurs in that same cycle, set wins.
- Result register keeps its last value until the next capture; reads while busy return the previous result.
- irq is level; it drops when done_flag clears or irq_en=0.

Optional Feature:
- FPU_HOST_TIMEOUT_EN defined:
  - Counter runs in wait_st and ack_st and resets on entry to start_st.
  - On reaching TIMEOUT_CYCLES: set err_tmo, drop fpu_ack, go to idle_st. done_flag is not set and the result is unchanged.
- FPU_HOST_TIMEOUT_EN undefined: no counter; status b4 reads 0; the FSM waits indefinitely.

Test Plan:
- Write A=0x3FC00000 (1.5), B=0x40100000 (2.25), command 0x00 → fpu_start pulses one cycle with op=0. FPU model returns 0x40700000. Check ack asserted until fpu_done falls, status=0x02, result bytes read 00,00,70,40.
- Command 0x82 (mul, irq_en), FPU returns 0x40580000 → irq=1 after the handshake; status read returns 0x82; irq=0 on the next cycle.
- Command 0x0C → no fpu_start, status=0x04; a second status read returns 0x00.
- Command 0x04 issued, then command 0x01 written while busy → fpu_operation stays 4, status b3=1 after completion. Rewriting A mid-op leaves fpu_a unchanged.
- arst pulsed while in ack_st → fpu_ack=0 and all outputs 0 immediately. The next command 0x05 runs normally.
- With FPU_HOST_TIMEOUT_EN and TIMEOUT_CYCLES=16, FPU never asserts done → back in idle after 16 cycles in wait_st, status=0x10, result register unchanged.
